counter_ctrl: RTL and testbench

Timer controller that sits directly upstream of `counter` and drives its `load`, `enab` and `cnt_in` inputs. It observes `cnt_out` to build a programmable one-shot or auto-reload timer: load a start value, count at a prescaled rate to an end value, flag terminal count. Software or an upstream FSM issues start/stop pulses; `tick` and `done` go to downstream logic.

---
 rtl/counter_ctrl_pkg.sv | 15 +
 rtl/counter.sv | 42 ++++
 rtl/strobe_div.sv | 52 +++++
 rtl/counter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared definitions for the timer controller: the FSM state encoding and
// its width. Imported by counter_ctrl.
package counter_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter.sv
// counter
// Loadable up-counter driven by counter_ctrl. load takes priority over enab;
// the count wraps modulo 2^WIDTH.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   load    - load cnt_in on the next edge
//   enab    - increment on the next edge
//   cnt_in  - load value
//   cnt_out - current count
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_r;

    // Count register: load wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= cnt_in;
        end else if (enab) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_out = cnt_r;

endmodule

// File: rtl/strobe_div.sv
// strobe_div
// Prescaler for the timer. While run is high, it counts 0..div and then wraps
// to 0. strobe is high in the cycle where the count equals div, so the
// attached counter advances once every div+1 run cycles.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   clr    - synchronous clear of the prescale count (issued on an accepted start)
//   run    - count enable (timer in RUN)
//   div    - terminal prescale value
//   strobe - one-cycle advance pulse (combinational)
module strobe_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);

    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] pre_cnt_r;
    logic             wrap_s;

    // Terminal detect and strobe decode
    always_comb begin
        wrap_s = (pre_cnt_r == div);
        strobe = run && wrap_s;
    end

    // Prescale counter: clear on start, wrap at div while running, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_r <= CNT_ZERO;
        end else if (clr) begin
            pre_cnt_r <= CNT_ZERO;
        end else if (run) begin
            if (wrap_s) begin
                pre_cnt_r <= CNT_ZERO;
            end else begin
                pre_cnt_r <= pre_cnt_r + CNT_ONE;
            end
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Timer controller sitting upstream of a loadable counter. On an accepted
// start it latches the run configuration, loads start_val into the counter,
// then lets the counter advance once per prescale period until cnt_out
// reaches end_val. One-shot runs finish in DONE; auto-reload runs reload the
// counter in the terminal cycle and keep running.
// Ports:
//   clk, rst   - clock and asynchronous active-low reset
//   start/stop - single-cycle run request / abort (stop has priority)
//   mode       - 0 one-shot, 1 auto-reload
//   start_val, end_val, prescale - run configuration, latched on start
//   cnt_out    - counter value fed back
//   cnt_in, load, enab - counter controls
//   busy, tick, done   - status to downstream logic
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      start_val,
    input  logic [WIDTH-1:0]      end_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cnt_out,
    output logic [WIDTH-1:0]      cnt_in,
    output logic                  load,
    output logic                  enab,
    output logic                  busy,
    output logic                  tick,
    output logic                  done
);

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  mode_r;
    logic [WIDTH-1:0]      start_val_r;
    logic [WIDTH-1:0]      end_val_r;
    logic [PRESCALE_W-1:0] prescale_r;

    logic                  accept_start_s;
    logic                  run_s;
    logic                  strobe_s;
    logic                  hit_s;

    strobe_div #(
        .DIV_W (PRESCALE_W)
    ) u_strobe_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_start_s),
        .run    (run_s),
        .div    (prescale_r),
        .strobe (strobe_s)
    );

    // Start acceptance and terminal-count detect
    always_comb begin
        accept_start_s = start && !stop &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE));
        run_s          = (state_r == ST_RUN);
        hit_s          = strobe_s && (cnt_out == end_val_r);
    end

    // Counter controls; stop masks every action in its cycle.
    // In auto-reload the terminal cycle reloads instead of incrementing,
    // so load and enab stay mutually exclusive.
    always_comb begin
        load = 1'b0;
        enab = 1'b0;
        tick = 1'b0;
        if (stop) begin
            load = 1'b0;
            enab = 1'b0;
            tick = 1'b0;
        end else begin
            load = (state_r == ST_LOAD) || (hit_s && mode_r);
            enab = strobe_s && !hit_s;
            tick = hit_s;
        end
    end

    // Status decode from state only
    always_comb begin
        busy   = (state_r == ST_LOAD) || (state_r == ST_RUN);
        done   = (state_r == ST_DONE);
        cnt_in = start_val_r;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_start_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (hit_s && !mode_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_start_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Configuration latch: captured only on an accepted start, frozen mid-run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r      <= 1'b0;
            start_val_r <= WIDTH'(0);
            end_val_r   <= WIDTH'(0);
            prescale_r  <= PRESCALE_W'(0);
        end else if (accept_start_s) begin
            mode_r      <= mode;
            start_val_r <= start_val;
            end_val_r   <= end_val;
            prescale_r  <= prescale;
        end else begin
            mode_r      <= mode_r;
            start_val_r <= start_val_r;
            end_val_r   <= end_val_r;
            prescale_r  <= prescale_r;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
// Self-checking bench for counter_ctrl attached to counter (WIDTH 5).
// A table of run configurations with hand-computed tick latency/period is
// applied in a loop; hand-written sequences cover the cycle-exact trace,
// stop/start priority, the degenerate start==end case and async reset.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [4:0] start_val;
    logic [4:0] end_val;
    logic [3:0] prescale;
    logic [4:0] cnt_out;
    logic [4:0] cnt_in;
    logic       load;
    logic       enab;
    logic       busy;
    logic       tick;
    logic       done;

    int n_total   = 0;
    int n_pass    = 0;
    int n_overlap = 0;

    typedef struct {
        logic       mode;
        logic [4:0] sv;
        logic [4:0] ev;
        logic [3:0] ps;
        int         lat;      // cycles from LOAD cycle to tick = (span+1)*(ps+1)
        int         periods;  // ticks to observe (auto-reload)
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    counter_ctrl #(
        .WIDTH      (5),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .start_val (start_val),
        .end_val   (end_val),
        .prescale  (prescale),
        .cnt_out   (cnt_out),
        .cnt_in    (cnt_in),
        .load      (load),
        .enab      (enab),
        .busy      (busy),
        .tick      (tick),
        .done      (done)
    );

    counter #(
        .WIDTH (5)
    ) u_counter (
        .clk     (clk),
        .rst     (1'b1),
        .load    (load),
        .enab    (enab),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out)
    );

    // load and enab must never be high together
    always @(negedge clk) begin
        if (load === 1'b1 && enab === 1'b1) n_overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a start; returns during the LOAD cycle. Inputs are scrambled
    // afterwards so the latched copy is what gets exercised.
    task automatic do_start(input logic m, input logic [4:0] sv,
                            input logic [4:0] ev, input logic [3:0] ps);
        mode = m; start_val = sv; end_val = ev; prescale = ps;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        mode = ~m; start_val = ~sv; end_val = ~ev; prescale = ~ps;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
    endtask

    // Advance until tick; cyc = -1 if the bound expires
    task automatic wait_tick(input int bound, output int cyc,
                             output int first_cnt, output int busy_low);
        cyc = -1; first_cnt = -1; busy_low = 0;
        for (int k = 1; k <= bound; k++) begin
            next_cycle();
            if (k == 1) first_cnt = int'(cnt_out);
            if (!busy) busy_low++;
            if (tick) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        vec_t v;
        int   c, fc, bl;
        int   exp_cnt[4];
        int   exp_en[4];
        int   exp_tk[4];

        vecs[0] = '{1'b0, 5'd3,  5'd6,  4'd0, 4,  1};
        vecs[1] = '{1'b0, 5'd30, 5'd1,  4'd0, 4,  1};
        vecs[2] = '{1'b1, 5'd0,  5'd3,  4'd2, 12, 5};
        vecs[3] = '{1'b1, 5'd9,  5'd9,  4'd0, 1,  4};
        vecs[4] = '{1'b0, 5'd10, 5'd10, 4'd3, 4,  1};
        vecs[5] = '{1'b0, 5'd0,  5'd31, 4'd0, 32, 1};
        vecs[6] = '{1'b1, 5'd5,  5'd7,  4'd1, 6,  3};

        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        start_val = 5'd0; end_val = 5'd0; prescale = 4'd0;

        // Reset state
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_load", int'(load), 0);
        check("rst_enab", int'(enab), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt_in", int'(cnt_in), 0);
        rst = 1'b1;
        next_cycle();

        // Table-driven runs
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            do_start(v.mode, v.sv, v.ev, v.ps);
            check($sformatf("v%0d_load_cycle", i), int'(load), 1);
            check($sformatf("v%0d_busy_load", i), int'(busy), 1);
            check($sformatf("v%0d_cnt_in", i), int'(cnt_in), int'(v.sv));
            for (int p = 0; p < v.periods; p++) begin
                wait_tick(200, c, fc, bl);
                check($sformatf("v%0d_p%0d_latency", i, p), c, v.lat);
                check($sformatf("v%0d_p%0d_first_cnt", i, p), fc, int'(v.sv));
                check($sformatf("v%0d_p%0d_busy_low", i, p), bl, 0);
                check($sformatf("v%0d_p%0d_cnt_at_tick", i, p), int'(cnt_out), int'(v.ev));
                check($sformatf("v%0d_p%0d_enab_at_tick", i, p), int'(enab), 0);
                check($sformatf("v%0d_p%0d_load_at_tick", i, p), int'(load), int'(v.mode));
            end
            if (v.mode == 1'b0) begin
                next_cycle();
                check($sformatf("v%0d_done", i), int'(done), 1);
                check($sformatf("v%0d_busy_done", i), int'(busy), 0);
            end else begin
                do_stop();
                check($sformatf("v%0d_idle_after_stop", i), int'(busy), 0);
            end
        end

        // Cycle-exact one-shot trace 3..6
        exp_cnt = '{3, 4, 5, 6};
        exp_en  = '{1, 1, 1, 0};
        exp_tk  = '{0, 0, 0, 1};
        do_start(1'b0, 5'd3, 5'd6, 4'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check($sformatf("trace_cnt%0d", k), int'(cnt_out), exp_cnt[k]);
            check($sformatf("trace_enab%0d", k), int'(enab), exp_en[k]);
            check($sformatf("trace_tick%0d", k), int'(tick), exp_tk[k]);
        end
        next_cycle();
        check("trace_done", int'(done), 1);

        // Degenerate start==end, auto-reload
        do_start(1'b1, 5'd9, 5'd9, 4'd0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check($sformatf("degen_tick%0d", k), int'(tick), 1);
            check($sformatf("degen_load%0d", k), int'(load), 1);
            check($sformatf("degen_enab%0d", k), int'(enab), 0);
            check($sformatf("degen_cnt%0d", k), int'(cnt_out), 9);
        end
        do_stop();

        // Start ignored mid-run, then stop at cnt_out 5 of a 3->20 run
        do_start(1'b0, 5'd3, 5'd20, 4'd0);
        next_cycle();                         // cnt 3
        next_cycle();                         // cnt 4
        mode = 1'b1; start_val = 5'd0; end_val = 5'd4; start = 1'b1;
        #1;
        check("midrun_start_load", int'(load), 0);
        check("midrun_start_tick", int'(tick), 0);
        next_cycle();
        start = 1'b0;
        check("midrun_start_cnt", int'(cnt_out), 5);
        check("midrun_start_cnt_in", int'(cnt_in), 3);
        check("midrun_start_busy", int'(busy), 1);
        stop = 1'b1;
        #1;
        check("stop_enab", int'(enab), 0);
        check("stop_load", int'(load), 0);
        check("stop_tick", int'(tick), 0);
        next_cycle();
        stop = 1'b0;
        check("stop_idle_busy", int'(busy), 0);
        check("stop_idle_done", int'(done), 0);
        check("stop_hold_cnt", int'(cnt_out), 5);
        next_cycle();
        check("stop_hold_cnt2", int'(cnt_out), 5);

        // Stop during LOAD suppresses the load
        do_start(1'b0, 5'd12, 5'd14, 4'd0);
        stop = 1'b1;
        #1;
        check("stop_in_load_load", int'(load), 0);
        next_cycle();
        stop = 1'b0;
        check("stop_in_load_idle", int'(busy), 0);
        check("stop_in_load_cnt", int'(cnt_out), 5);

        // start and stop together in IDLE
        start_val = 5'd7; end_val = 5'd8; start = 1'b1; stop = 1'b1;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        check("start_stop_load", int'(load), 0);
        next_cycle();
        check("start_stop_busy2", int'(busy), 0);
        check("start_stop_cnt_in", int'(cnt_in), 12);

        // Asynchronous reset mid-run, then a clean restart
        do_start(1'b1, 5'd2, 5'd9, 4'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_enab", int'(enab), 0);
        check("arst_load", int'(load), 0);
        check("arst_tick", int'(tick), 0);
        check("arst_done", int'(done), 0);
        check("arst_cnt_in", int'(cnt_in), 0);
        #2;
        rst = 1'b1;
        next_cycle();
        check("arst_idle", int'(busy), 0);
        do_start(1'b0, 5'd1, 5'd3, 4'd0);
        wait_tick(50, c, fc, bl);
        check("arst_restart_lat", c, 3);
        check("arst_restart_cnt", int'(cnt_out), 3);
        next_cycle();
        check("arst_restart_done", int'(done), 1);

        check("load_enab_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
